// File: rtl/hack_pkg.sv
// Shared definitions for the Hack fetch stage: word geometry and fetch FSM states.
package hack_pkg;

    localparam int WORD_W     = 16;
    localparam int AINSTR_BIT = 15;

    typedef enum logic [1:0] {
        WAIT_ROM,
        PRIME,
        RUN,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/hack_halt_detect.sv
// Remembers the most recent retired A-instruction and flags the canonical
// end-of-program idiom: "@k" at address k followed by "0;JMP" at k+1.
module hack_halt_detect
    import hack_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              retire_i,
    input  logic [WORD_W-1:0] instr_i,
    input  logic [WORD_W-1:0] instr_pc_i,
    input  logic              jump_i,
    input  logic [WORD_W-1:0] jump_target_i,
    output logic              halt_hit_o
);

    logic [WORD_W-1:0] lastAValue_q;
    logic              lastAValid_q;
    logic [WORD_W-1:0] pcMinusOne;

    // Track whether the instruction just retired loaded A with a known constant.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lastAValue_q <= '0;
            lastAValid_q <= 1'b0;
        end else if (retire_i) begin
            if (!instr_i[AINSTR_BIT]) begin
                lastAValue_q <= instr_i;
                lastAValid_q <= 1'b1;
            end else begin
                lastAValid_q <= 1'b0;
            end
        end
    end

    // A jump back to the A-instruction immediately before it is a self-loop.
    always_comb begin
        pcMinusOne = instr_pc_i - WORD_W'(1);
        halt_hit_o = jump_i & lastAValid_q
                   & (jump_target_i == lastAValue_q)
                   & (jump_target_i == pcMinusOne);
    end

endmodule

// File: rtl/hack_fetch.sv
// Fetch stage between the Hack core and the ROM. Waits for the ROM to finish
// loading, primes the one-cycle read pipeline, then feeds the core one
// instruction per retire with jumps and stalls applied without bubbles.
module hack_fetch
    import hack_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clken,
    input  logic              rom_ready,
    output logic [WORD_W-1:0] rom_address,
    input  logic [WORD_W-1:0] rom_instruction,
    input  logic              stall,
    input  logic              jump,
    input  logic [WORD_W-1:0] jump_target,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  retired_q;
    logic [WORD_W-1:0] nextPc;
    logic              retire;
    logic              haltHit;

    hack_halt_detect u_halt_detect (
        .clk           (clk),
        .resetn        (resetn),
        .retire_i      (retire),
        .instr_i       (instr),
        .instr_pc_i    (pc_q),
        .jump_i        (jump),
        .jump_target_i (jump_target),
        .halt_hit_o    (haltHit)
    );

    // Next-state, next-PC and ROM address; the PC register always follows the
    // address sent to the ROM so returned data lines up with instr_pc.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        rom_address = pc_q;
        instr_valid = 1'b0;
        halted      = 1'b0;
        retire      = (state_q == RUN) & clken & ~stall;
        nextPc      = pc_q;
        if (retire) begin
            nextPc = jump ? jump_target : pc_q + WORD_W'(1);
        end
        case (state_q)
            WAIT_ROM: begin
                rom_address = RESET_PC;
                pc_d        = RESET_PC;
                if (rom_ready) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                rom_address = RESET_PC;
                pc_d        = RESET_PC;
                state_d     = rom_ready ? RUN : WAIT_ROM;
            end
            RUN: begin
                instr_valid = 1'b1;
                rom_address = nextPc;
                pc_d        = nextPc;
                if (!rom_ready) begin
                    state_d = WAIT_ROM;
                    pc_d    = RESET_PC;
                end else if (haltHit && retire) begin
                    state_d = HALT;
                end
            end
            HALT: begin
                halted      = 1'b1;
                rom_address = pc_q;
            end
            default: begin
                state_d = WAIT_ROM;
            end
        endcase
    end

    // State, PC and retired-instruction counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= WAIT_ROM;
            pc_q      <= RESET_PC;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (retire) begin
                retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // ROM data passes straight through only while it is meaningful.
    always_comb begin
        instr    = instr_valid ? rom_instruction : '0;
        instr_pc = pc_q;
        retired  = retired_q;
    end

endmodule

// File: tb/tb_hack_fetch.sv
// Self-checking bench for hack_fetch: a ROM model with one-cycle latency, a
// behavioural reference of the fetch rules, directed scenarios and a random phase.
module tb_hack_fetch;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        clken = 1'b1;
    logic        romReady = 1'b0;
    logic [15:0] romAddress;
    logic [15:0] romInstruction = 16'h0000;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [15:0] jumpTarget = 16'h0000;
    logic [15:0] instr;
    logic [15:0] instrPc;
    logic        instrValid;
    logic        halted;
    logic [31:0] retired;

    logic [15:0] romMem [65536];

    int compareCount = 0;
    int mismatchCount = 0;

    // Reference model state
    logic [15:0] mPc;
    logic [31:0] mRetired;
    bit          mHalted;
    int          mStreak;
    logic [15:0] mLastA;
    bit          mLastAValid;

    hack_fetch #(
        .RESET_PC (16'h0000),
        .CNT_W    (32)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .clken           (clken),
        .rom_ready       (romReady),
        .rom_address     (romAddress),
        .rom_instruction (romInstruction),
        .stall           (stall),
        .jump            (jump),
        .jump_target     (jumpTarget),
        .instr           (instr),
        .instr_pc        (instrPc),
        .instr_valid     (instrValid),
        .halted          (halted),
        .retired         (retired)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Synchronous ROM: data for an address appears one clock later.
    always @(posedge clk) begin
        romInstruction <= romMem[romAddress];
    end

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPc         = 16'h0000;
        mRetired    = 32'd0;
        mHalted     = 1'b0;
        mStreak     = 0;
        mLastA      = 16'h0000;
        mLastAValid = 1'b0;
    endtask

    // Valid once rom_ready has been seen high on two consecutive edges;
    // a retire consumes the instruction at the current PC.
    task automatic modelStep();
        logic [15:0] cur;
        logic [15:0] pcm1;
        bit          retireNow;
        bit          hit;
        if (!resetn) begin
            modelReset();
            return;
        end
        if (mHalted) return;
        retireNow = (mStreak >= 2) && clken && !stall;
        cur  = romMem[mPc];
        pcm1 = mPc - 16'd1;
        hit  = 1'b0;
        if (retireNow) begin
            mRetired = mRetired + 32'd1;
            hit = jump && mLastAValid && (jumpTarget == mLastA) && (jumpTarget == pcm1);
            if (!cur[15]) begin
                mLastA      = cur;
                mLastAValid = 1'b1;
            end else begin
                mLastAValid = 1'b0;
            end
            mPc = jump ? jumpTarget : mPc + 16'd1;
        end
        if (!romReady) begin
            mStreak = 0;
            mPc     = 16'h0000;
        end else begin
            if (mStreak < 2) mStreak++;
            if (hit) mHalted = 1'b1;
        end
    endtask

    task automatic checkAll();
        bit expValid;
        expValid = (mStreak >= 2) && !mHalted;
        checkOutput("valid", {31'd0, instrValid}, {31'd0, expValid});
        checkOutput("pc", {16'd0, instrPc}, {16'd0, mPc});
        checkOutput("instr", {16'd0, instr}, expValid ? {16'd0, romMem[mPc]} : 32'd0);
        checkOutput("halted", {31'd0, halted}, {31'd0, mHalted});
        checkOutput("retired", retired, mRetired);
    endtask

    task automatic driveInputs(input bit rdy, input bit ce, input bit st, input bit jmp, input logic [15:0] tgt);
        romReady   = rdy;
        clken      = ce;
        stall      = st;
        jump       = jmp;
        jumpTarget = tgt;
        #1;
    endtask

    task automatic stepClock();
        modelStep();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic applyStimulus(input bit rdy, input bit ce, input bit st, input bit jmp, input logic [15:0] tgt);
        driveInputs(rdy, ce, st, jmp, tgt);
        stepClock();
    endtask

    // Reset pulse followed by ROM-ready bring-up into RUN.
    task automatic resetAndBringUp();
        driveInputs(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        resetn = 1'b0;
        modelReset();
        @(posedge clk);
        #3;
        resetn = 1'b1;
        #1;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
    endtask

    initial begin
        for (int n = 0; n < 65536; n++) begin
            romMem[n] = 16'(n) ^ 16'hA5A5;
        end
        romMem[16'h0010] = 16'h0010;
        romMem[16'h0011] = 16'hEA87;
        modelReset();

        // Reset state
        #2;
        checkAll();
        checkOutput("resetAddr", {16'd0, romAddress}, 32'd0);
        #10;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // ROM not ready for 10 clocks: address pinned, nothing valid
        for (int i = 0; i < 10; i++) begin
            driveInputs(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
            checkOutput("waitAddr", {16'd0, romAddress}, 32'd0);
            stepClock();
        end
        // ROM ready: valid must appear exactly two clocks later
        for (int i = 0; i < 2; i++) begin
            driveInputs(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
            checkOutput("primeAddr", {16'd0, romAddress}, 32'd0);
            stepClock();
        end
        checkOutput("validRise", {31'd0, instrValid}, 32'd1);

        // Straight-line fetch of four instructions
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        end
        checkOutput("retired4", retired, 32'd4);

        // Advance to PC 5, stall three clocks, then release
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            driveInputs(1'b1, 1'b1, 1'b1, 1'b1, 16'h0200);
            checkOutput("stallAddr", {16'd0, romAddress}, 32'd5);
            stepClock();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        checkOutput("afterStall", {16'd0, instrPc}, 32'd6);

        // Jump from PC 7 to 0x0100
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0100);
        checkOutput("jumpPc", {16'd0, instrPc}, 32'h100);

        // End-of-program loop at 0x0010/0x0011
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010);
        checkOutput("haltFlag", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            driveInputs(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)));
            checkOutput("haltAddr", {16'd0, romAddress}, 32'h10);
            stepClock();
        end

        // Asynchronous reset in the middle of RUN at PC 0x42
        resetAndBringUp();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 16'h0042);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000);
        checkOutput("preResetPc", {16'd0, instrPc}, 32'h42);
        #2;
        resetn = 1'b0;
        #1;
        modelReset();
        checkAll();
        checkOutput("midResetAddr", {16'd0, romAddress}, 32'd0);
        stepClock();
        #2;
        resetn = 1'b1;
        #1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);

        // Random traffic: clock enable gaps, stalls, jumps, ROM reloads
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 9999));
            applyStimulus((r % 53) != 0, (r % 7) != 0, (r % 5) == 0, (r % 6) == 0,
                          16'($urandom_range(0, 65535)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
